// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: walks a frame region in bursts over a DDR read port and streams words out on valid/ready.
// Optional DDR_READER_PREFETCH_EN keeps a second burst in flight while the current one drains.
module ddr_frame_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 30,
  parameter int CNT_W     = 21,
  parameter int BURST_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [CNT_W-1:0]  frame_words,
  input  logic              frame_start,
  input  logic              cmd_full,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_empty,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);
  localparam int LW = $clog2(BURST_MAX + 1);
`ifdef DDR_READER_PREFETCH_EN
  localparam int OW = LW + 1;
`else
  localparam int OW = LW;
`endif
  typedef enum logic [2:0] {CALIB, IDLE, ISSUE, DRAIN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [ADDR_W-1:0] addr_q, addr_d, cmd_addr_q, cmd_addr_d;
  logic [CNT_W-1:0] rem_q, rem_d, dlv_q, dlv_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [5:0] cmd_bl_q, cmd_bl_d;
  logic [2:0] cmd_instr_q;
  logic cmd_en_q, cmd_en_d;
  logic [LW-1:0] len;
  logic issue, accept, pop, busy_w;
  always_comb begin
    busy_w = state_q inside {ISSUE, DRAIN, FLUSH};
    len = rem_q < CNT_W'(BURST_MAX) ? LW'(rem_q) : LW'(BURST_MAX);
    out_valid = state_q == DRAIN && !frame_start && !rd_empty && outst_q != '0;
    out_data = out_valid ? rd_data : '0;
    out_last = out_valid && dlv_q == CNT_W'(1);
    accept = out_valid && out_ready;
    // an abort drains only words already requested, never anything beyond
    pop = accept || (state_q == FLUSH && !rd_empty && outst_q != '0);
`ifdef DDR_READER_PREFETCH_EN
    issue = !cmd_full && !frame_start && rem_q != '0 && (state_q == ISSUE ||
            (state_q == DRAIN && 32'(outst_q) + 32'(len) <= 2 * BURST_MAX));
`else
    issue = !cmd_full && !frame_start && rem_q != '0 && state_q == ISSUE;
`endif
    rem_d = issue ? rem_q - CNT_W'(len) : rem_q;
    addr_d = issue ? addr_q + ADDR_W'(32'(len) * (DATA_W / 8)) : addr_q;
    outst_d = outst_q + (issue ? OW'(len) : '0) - OW'(pop);
    dlv_d = dlv_q - CNT_W'(accept);
    cmd_en_d = issue;
    cmd_bl_d = issue ? 6'(len - LW'(1)) : cmd_bl_q;
    cmd_addr_d = issue ? addr_q : cmd_addr_q;
    state_d = state_q;
    if (state_q == CALIB) state_d = sync_q[1] ? IDLE : CALIB;
    else if (frame_start) begin
      addr_d = frame_base;
      rem_d = frame_words;
      dlv_d = frame_words;
      state_d = busy_w ? FLUSH : (frame_words != '0 ? ISSUE : DONE);
    end
    else if (state_q == ISSUE && issue) state_d = DRAIN;
    else if ((state_q == DRAIN || state_q == FLUSH) && outst_d == '0) state_d = rem_d != '0 ? ISSUE : DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CALIB;
      sync_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      dlv_q <= '0;
      outst_q <= '0;
      cmd_en_q <= 1'b0;
      cmd_bl_q <= '0;
      cmd_addr_q <= '0;
      cmd_instr_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], mem_calib_done};
      addr_q <= addr_d;
      rem_q <= rem_d;
      dlv_q <= dlv_d;
      outst_q <= outst_d;
      cmd_en_q <= cmd_en_d;
      cmd_bl_q <= cmd_bl_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_instr_q <= 3'b001;
    end
  end
  assign cmd_en = cmd_en_q;
  assign cmd_instr = cmd_instr_q;
  assign cmd_bl = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign rd_en = pop;
  assign busy = busy_w;
  assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb_ddr_frame_reader: drives ddr_frame_reader against a queue-based DDR read-port model and
// checks command lists and output streams against arithmetic expectations.
module tb_ddr_frame_reader;
  localparam int DW = 32, AW = 30, CW = 21;
  logic clk = 1'b0, reset, mem_calib_done, frame_start, cmd_full;
  logic rd_empty = 1'b1, out_ready = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] frame_base;
  logic [CW-1:0] frame_words;
  logic cmd_en, rd_en, out_valid, out_last, busy, frame_done;
  logic [2:0] cmd_instr;
  logic [5:0] cmd_bl;
  logic [AW-1:0] cmd_byte_addr;
  logic [DW-1:0] out_data;

  ddr_frame_reader dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done), .frame_base(frame_base),
    .frame_words(frame_words), .frame_start(frame_start), .cmd_full(cmd_full), .cmd_en(cmd_en),
    .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_en(rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, full_cyc = 0, last_acc_cyc = 0;
  int acc_cnt = 0, mism_pop = 0, underflow = 0, outst = 0, max_outst = 0;
  logic rnd_ready = 1'b0, rnd_stall = 1'b0;
  logic [DW-1:0] fifo[$];
  logic [DW:0] out_log[$], exp_out[$];
  logic [5:0] bl_log[$], exp_bl[$];
  logic [AW-1:0] ca_log[$], exp_ca[$];
  int cc_log[$];
  logic vl_log[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[29:2], 4'hA};
  endfunction

  // expected stream: n words of a frame of 'total' words starting at byte address b
  function automatic void add_words(input logic [AW-1:0] b, input int n, input int total);
    for (int i = 0; i < n; i++) exp_out.push_back({i == total - 1, mem_word(b + AW'(4 * i))});
  endfunction

  function automatic void add_cmds(input logic [AW-1:0] b, input int total);
    for (int off = 0; off < total; off += 64) begin
      int l = (total - off < 64) ? total - off : 64;
      exp_bl.push_back(6'(l - 1));
      exp_ca.push_back(b + AW'(4 * off));
    end
  endfunction

  // memory controller model plus bus monitor
  always @(posedge clk) begin
    cyc++;
    if (frame_start) start_cyc = cyc;
    if (cmd_full) full_cyc = cyc;
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (rd_en !== (out_valid && out_ready)) mism_pop++;
    if (rd_en) begin
      if (fifo.size() == 0) underflow++; else void'(fifo.pop_front());
      outst--;
    end
    if (out_valid && out_ready) begin
      out_log.push_back({out_last, out_data});
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (cmd_en) begin
      bl_log.push_back(cmd_bl);
      ca_log.push_back(cmd_byte_addr);
      cc_log.push_back(cyc);
      vl_log.push_back(out_valid);
      for (int i = 0; i <= int'(cmd_bl); i++) fifo.push_back(mem_word(cmd_byte_addr + AW'(4 * i)));
      outst += int'(cmd_bl) + 1;
    end
    if (outst > max_outst) max_outst = outst;
  end

  always @(negedge clk) begin
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_empty = fifo.size() == 0 || (rnd_stall && $urandom_range(0, 3) == 0);
    rd_data = fifo.size() != 0 ? fifo[0] : '0;
  end

  task automatic clear_logs;
    @(negedge clk);
    out_log.delete(); exp_out.delete(); bl_log.delete(); exp_bl.delete();
    ca_log.delete(); exp_ca.delete(); cc_log.delete(); vl_log.delete();
    done_cnt = 0; acc_cnt = 0; mism_pop = 0; max_outst = 0;
  endtask

  task automatic pulse(input logic [AW-1:0] b, input int w);
    frame_base = b;
    frame_words = CW'(w);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 4000) begin @(negedge clk); t++; end
    checks++;
    if (done_cnt < n) begin
      failures++;
      $display("FAIL wait_done: frame_done count %0d, required %0d within bound", done_cnt, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 4000) begin @(negedge clk); t++; end
    checks++;
    if (acc_cnt < n) begin
      failures++;
      $display("FAIL wait_acc: accepted %0d, required %0d within bound", acc_cnt, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_calib_done = 1'b0; frame_start = 1'b0; cmd_full = 1'b0;
    frame_base = '0; frame_words = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en, out_valid, out_last, busy, frame_done, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b instr=%b bl=%0d addr=%h busy=%b done=%b, required all zero",
               cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, busy, frame_done);
    end
    reset = 1'b1;
    @(negedge clk);
    pulse(30'h40, 1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_en !== 1'b0) begin
      failures++;
      $display("FAIL calib_block: busy=%b cmd_en=%b before calibration, required 0/0", busy, cmd_en);
    end
    clear_logs();
    mem_calib_done = 1'b1;
    repeat (3) @(negedge clk);
    pulse(30'h40, 1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL calib_ready: busy=%b after calibration latency, required 1", busy);
    end
    wait_done(1);
    checks++;
    if (out_log.size() != 1 || out_log[0] !== {1'b1, mem_word(30'h40)}) begin
      failures++;
      $display("FAIL calib_word: got %0d words first %h, required 1 word %h", out_log.size(), out_log[0], {1'b1, mem_word(30'h40)});
    end
    checks++;
    if (cmd_instr !== 3'b001) begin
      failures++;
      $display("FAIL cmd_instr: got %b, required 001", cmd_instr);
    end
  endtask

  task automatic test_basic;
    int errs = 0;
    clear_logs();
    add_words(30'h1000, 200, 200);
    add_cmds(30'h1000, 200);
    pulse(30'h1000, 200);
    wait_done(1);
    checks++;
    if (bl_log.size() != exp_bl.size()) begin
      failures++; $display("FAIL basic_cmd_count: got %0d, required %0d", bl_log.size(), exp_bl.size());
    end
    foreach (exp_bl[i]) if (i < bl_log.size() && (bl_log[i] !== exp_bl[i] || ca_log[i] !== exp_ca[i])) begin
      if (errs == 0) $display("FAIL basic_cmd: #%0d got (%0d,%h) required (%0d,%h)", i, bl_log[i], ca_log[i], exp_bl[i], exp_ca[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
    checks++;
    if (cc_log.size() == 0 || cc_log[0] != start_cyc + 2) begin
      failures++; $display("FAIL basic_cmd_latency: first cmd cycle %0d, required %0d", cc_log.size() ? cc_log[0] : -1, start_cyc + 2);
    end
    checks++;
    if (out_log.size() != exp_out.size()) begin
      failures++; $display("FAIL basic_word_count: got %0d, required %0d", out_log.size(), exp_out.size());
    end
    errs = 0;
    foreach (exp_out[i]) if (i < out_log.size() && out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL basic_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
    checks++;
    if (done_cnt != 1 || done_cyc != last_acc_cyc + 1) begin
      failures++; $display("FAIL basic_done: count %0d at cycle %0d, required 1 at %0d", done_cnt, done_cyc, last_acc_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b, required 0", busy); end
  endtask

  task automatic test_random_ready;
    int errs = 0;
    logic [AW-1:0] b = AW'($urandom);
    clear_logs();
    rnd_ready = 1'b1; rnd_stall = 1'b1;
    add_words(b, 130, 130);
    add_cmds(b, 130);
    pulse(b, 130);
    wait_done(1);
    rnd_ready = 1'b0; rnd_stall = 1'b0;
    checks++;
    if (out_log.size() != exp_out.size() || bl_log.size() != exp_bl.size()) begin
      failures++; $display("FAIL rand_counts: words %0d cmds %0d, required %0d %0d", out_log.size(), bl_log.size(), exp_out.size(), exp_bl.size());
    end
    foreach (exp_out[i]) if (i < out_log.size() && out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL rand_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    foreach (exp_bl[i]) if (i < bl_log.size() && (bl_log[i] !== exp_bl[i] || ca_log[i] !== exp_ca[i])) begin
      if (errs == 0) $display("FAIL rand_cmd: #%0d got (%0d,%h) required (%0d,%h)", i, bl_log[i], ca_log[i], exp_bl[i], exp_ca[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
    checks++;
    if (mism_pop != 0 || underflow != 0) begin
      failures++; $display("FAIL rand_rd_en: rd_en/accept mismatches %0d underflows %0d, required 0 0", mism_pop, underflow);
    end
  endtask

  task automatic test_cmd_full;
    int errs = 0;
    clear_logs();
    add_cmds(30'h5000, 100);
    add_words(30'h5000, 100, 100);
    cmd_full = 1'b1;
    pulse(30'h5000, 100);
    repeat (10) @(negedge clk);
    cmd_full = 1'b0;
    wait_done(1);
    checks++;
    if (cc_log.size() == 0 || cc_log[0] != full_cyc + 2) begin
      failures++; $display("FAIL full_latency: first cmd cycle %0d, required %0d", cc_log.size() ? cc_log[0] : -1, full_cyc + 2);
    end
    checks++;
    if (bl_log.size() != exp_bl.size() || out_log.size() != exp_out.size()) begin
      failures++; $display("FAIL full_counts: cmds %0d words %0d, required %0d %0d", bl_log.size(), out_log.size(), exp_bl.size(), exp_out.size());
    end
    foreach (exp_bl[i]) if (i < bl_log.size() && (bl_log[i] !== exp_bl[i] || ca_log[i] !== exp_ca[i])) begin
      if (errs == 0) $display("FAIL full_cmd: #%0d got (%0d,%h) required (%0d,%h)", i, bl_log[i], ca_log[i], exp_bl[i], exp_ca[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
  endtask

  task automatic test_abort;
    int errs = 0, pre = 0, abort_cyc;
    clear_logs();
    add_cmds(30'h2000, 256);
    add_words(30'h2000, 70, 256);
    add_words(30'h8000, 64, 64);
    pulse(30'h2000, 256);
    wait_acc(70);
    pulse(30'h8000, 64);
    abort_cyc = start_cyc;
    wait_done(1);
    foreach (cc_log[i]) if (cc_log[i] <= abort_cyc) begin
      pre++;
      if (bl_log[i] !== exp_bl[i] || ca_log[i] !== exp_ca[i]) begin
        if (errs == 0) $display("FAIL abort_pre_cmd: #%0d got (%0d,%h) required (%0d,%h)", i, bl_log[i], ca_log[i], exp_bl[i], exp_ca[i]);
        errs++;
      end
    end
    checks++; if (errs != 0) failures++;
    checks++;
    if (bl_log.size() != pre + 1 || bl_log[pre] !== 6'd63 || ca_log[pre] !== 30'h8000) begin
      failures++; $display("FAIL abort_new_cmd: %0d cmds after abort, first (%0d,%h), required 1 of (63,8000)",
                           bl_log.size() - pre, bl_log[pre], ca_log[pre]);
    end
    checks++;
    if (out_log.size() != exp_out.size()) begin
      failures++; $display("FAIL abort_word_count: got %0d, required %0d", out_log.size(), exp_out.size());
    end
    errs = 0;
    foreach (exp_out[i]) if (i < out_log.size() && out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL abort_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
    checks++;
    if (done_cnt != 1 || fifo.size() != 0 || underflow != 0) begin
      failures++; $display("FAIL abort_done: done %0d left %0d underflow %0d, required 1 0 0", done_cnt, fifo.size(), underflow);
    end
  endtask

  task automatic test_zero_and_wrap;
    int errs = 0;
    clear_logs();
    pulse(30'h1234, 0);
    wait_done(1);
    checks++;
    if (bl_log.size() != 0 || done_cnt != 1 || done_cyc != start_cyc + 1) begin
      failures++; $display("FAIL zero_frame: cmds %0d done %0d at %0d, required 0 1 at %0d", bl_log.size(), done_cnt, done_cyc, start_cyc + 1);
    end
    clear_logs();
    add_cmds(30'h3FFFFF00, 128);
    add_words(30'h3FFFFF00, 128, 128);
    pulse(30'h3FFFFF00, 128);
    wait_done(1);
    checks++;
    if (bl_log.size() != 2 || ca_log[1] !== 30'h0 || bl_log[1] !== exp_bl[1] || ca_log[0] !== exp_ca[0]) begin
      failures++; $display("FAIL wrap_cmd: %0d cmds second (%0d,%h), required 2 with (63,0)", bl_log.size(), bl_log[1], ca_log[1]);
    end
    checks++;
    if (out_log.size() != exp_out.size()) begin
      failures++; $display("FAIL wrap_word_count: got %0d, required %0d", out_log.size(), exp_out.size());
    end
    foreach (exp_out[i]) if (i < out_log.size() && out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL wrap_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
  endtask

  task automatic test_back_to_back;
    int errs = 0, t = 0;
    clear_logs();
    add_words(30'h100, 10, 10);
    add_words(30'h900, 20, 20);
    pulse(30'h100, 10);
    while (frame_done !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    pulse(30'h900, 20);
    wait_done(2);
    checks++;
    if (done_cnt != 2 || out_log.size() != exp_out.size()) begin
      failures++; $display("FAIL b2b_counts: done %0d words %0d, required 2 %0d", done_cnt, out_log.size(), exp_out.size());
    end
    foreach (exp_out[i]) if (i < out_log.size() && out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL b2b_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
  endtask

  task automatic test_prefetch;
    int errs = 0;
    clear_logs();
    add_words(30'h4000, 256, 256);
    pulse(30'h4000, 256);
    wait_done(1);
    foreach (exp_out[i]) if (i >= out_log.size() || out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL pf_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
`ifdef DDR_READER_PREFETCH_EN
    checks++;
    if (max_outst > 128 || vl_log.size() < 2 || vl_log[1] !== 1'b1) begin
      failures++; $display("FAIL pf_overlap: max outstanding %0d second-cmd valid %b, required <=128 and 1", max_outst, vl_log[1]);
    end
`else
    checks++;
    if (max_outst > 64 || vl_log.size() < 2 || vl_log[1] !== 1'b0) begin
      failures++; $display("FAIL single_burst: max outstanding %0d second-cmd valid %b, required <=64 and 0", max_outst, vl_log[1]);
    end
`endif
  endtask

  task automatic test_async_reset;
    int errs = 0;
    clear_logs();
    pulse(30'h6000, 200);
    wait_acc(30);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en, out_valid, out_last, busy, frame_done} !== '0) begin
      failures++; $display("FAIL async_reset: got en=%b rd_en=%b valid=%b busy=%b, required all zero", cmd_en, rd_en, out_valid, busy);
    end
    @(negedge clk);
    fifo.delete();
    outst = 0;
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    add_words(30'h700, 5, 5);
    repeat (2) @(negedge clk);
    pulse(30'h700, 5);
    wait_done(1);
    checks++;
    if (out_log.size() != exp_out.size()) begin
      failures++; $display("FAIL recover_count: got %0d, required %0d", out_log.size(), exp_out.size());
    end
    foreach (exp_out[i]) if (i < out_log.size() && out_log[i] !== exp_out[i]) begin
      if (errs == 0) $display("FAIL recover_word: #%0d got %h required %h", i, out_log[i], exp_out[i]);
      errs++;
    end
    checks++; if (errs != 0) failures++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_cmd_full();
    test_abort();
    test_zero_and_wrap();
    test_back_to_back();
    test_prefetch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
